// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry / MRET sequencer driving a single CSR write port
module trap_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        irq,
  input  logic        mret_valid,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        exc_ack,
  output logic        irq_ack,
  output logic        mret_ack,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS, REDIRECT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic [31:0] r_mstatus;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_redirect_pc;

  logic        w_idle;
  logic        w_irq_en;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_mret;
  logic        w_accept;
  logic [31:0] w_trap_status;
  logic [31:0] w_mret_status;
  logic [31:0] w_base;
  logic [31:0] w_trap_target;
  logic [31:0] w_mret_target;
  logic        w_unused;

  // Arbitration is gated by reset so acks stay low while reset is held.
  assign w_idle      = reset && (r_state == IDLE);
  assign w_irq_en    = irq & mstatus_in[3] & mie_in[11];
  assign w_take_exc  = w_idle & exc_valid;
  assign w_take_irq  = w_idle & ~exc_valid & w_irq_en;
  assign w_take_mret = w_idle & ~exc_valid & ~w_irq_en & mret_valid;
  assign w_accept    = w_take_exc | w_take_irq | w_take_mret;

  assign exc_ack  = w_take_exc;
  assign irq_ack  = w_take_irq;
  assign mret_ack = w_take_mret;

  assign busy  = (reset && (r_state != IDLE)) | w_accept;
  assign flush = busy;

  assign redirect_valid = (r_state == REDIRECT);
  assign redirect_pc    = r_redirect_pc;

  always_comb begin
    w_trap_status        = r_mstatus;
    w_trap_status[7]     = r_mstatus[3];
    w_trap_status[3]     = 1'b0;
    w_trap_status[12:11] = 2'b11;
    w_mret_status        = r_mstatus;
    w_mret_status[3]     = r_mstatus[7];
    w_mret_status[7]     = 1'b1;
    w_mret_status[12:11] = 2'b11;
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign w_base        = {r_mtvec[31:2], 2'b00};
  assign w_trap_target = ((r_mtvec[1:0] == 2'b01) && r_cause[31]) ?
                         (w_base + {25'b0, r_cause[4:0], 2'b00}) : w_base;
  assign w_mret_target = {r_mepc[31:2], 2'b00};

  always_comb begin
    csr_we    = 1'b0;
    csr_addr  = 12'h000;
    csr_wdata = 32'h0;
    case (r_state)
      W_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h341;
        csr_wdata = {r_pc[31:2], 2'b00};
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h342;
        csr_wdata = r_cause;
      end
      W_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h343;
        csr_wdata = r_tval;
      end
      W_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = w_trap_status;
      end
      M_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = w_mret_status;
      end
      default: begin
        csr_we    = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= 32'h0;
      r_cause       <= 32'h0;
      r_tval        <= 32'h0;
      r_mstatus     <= 32'h0;
      r_mtvec       <= 32'h0;
      r_mepc        <= 32'h0;
      r_redirect_pc <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pc      <= exc_pc;
            r_cause   <= w_take_exc ? {27'b0, exc_cause} :
                         (w_take_irq ? 32'h8000_000B : 32'h0);
            r_tval    <= w_take_exc ? exc_tval : 32'h0;
            r_mstatus <= mstatus_in;
            r_mtvec   <= mtvec_in;
            r_mepc    <= mepc_in;
            r_state   <= w_take_mret ? M_STATUS : W_EPC;
          end
        end
        W_EPC:   r_state <= W_CAUSE;
        W_CAUSE: r_state <= W_TVAL;
        W_TVAL:  r_state <= W_STATUS;
        W_STATUS: begin
          r_redirect_pc <= w_trap_target;
          r_state       <= REDIRECT;
        end
        M_STATUS: begin
          r_redirect_pc <= w_mret_target;
          r_state       <= REDIRECT;
        end
        REDIRECT: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign w_unused = ^{mie_in[31:12], mie_in[10:0], r_pc[1:0], r_mepc[1:0]};

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        irq;
  logic        mret_valid;
  logic [31:0] mstatus_in;
  logic [31:0] mie_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        exc_ack;
  logic        irq_ack;
  logic        mret_ack;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        flush;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  trap_sequencer dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .irq(irq), .mret_valid(mret_valid),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exc_ack(exc_ack), .irq_ack(irq_ack), .mret_ack(mret_ack),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .flush(flush), .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; irq = 0; mret_valid = 0;
    mstatus_in = 0; mie_in = 0; mtvec_in = 0; mepc_in = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    exc_valid = 1; irq = 1; mret_valid = 1; mstatus_in = 32'h8; mie_in = 32'h800;
    @(negedge clk); #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_acks got %b expected 000", {exc_ack, irq_ack, mret_ack});
    end
    checks++;
    if ({busy, flush, csr_we, redirect_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {busy, flush, csr_we, redirect_valid});
    end
    checks++;
    if ({csr_addr, csr_wdata, redirect_pc} !== 76'h0) begin
      errors++; $display("FAIL reset_data got addr=%h data=%h rpc=%h expected 0", csr_addr, csr_wdata, redirect_pc);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1;
  endtask

  task automatic test_exception();
    logic [11:0] ea [4];
    logic [31:0] ed [4];
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ed = '{32'h100, 32'h2, 32'hDEAD, 32'h1880};
    @(negedge clk);
    exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    mtvec_in = 32'h8000; mstatus_in = 32'h8;
    #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack} !== 3'b100) begin
      errors++; $display("FAIL exc_accept_acks got %b expected 100", {exc_ack, irq_ack, mret_ack});
    end
    checks++;
    if ({busy, flush, csr_we} !== 3'b110) begin
      errors++; $display("FAIL exc_accept_flags got %b expected 110", {busy, flush, csr_we});
    end
    @(negedge clk);
    exc_valid = 0; exc_pc = 32'hFFFF_FFFF; exc_tval = 0; mtvec_in = 0; mstatus_in = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({csr_we, csr_addr, csr_wdata} !== {1'b1, ea[c], ed[c]}) begin
        errors++;
        $display("FAIL exc_csr[%0d] got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 c, csr_we, csr_addr, csr_wdata, ea[c], ed[c]);
      end
      checks++;
      if ({redirect_valid, busy, exc_ack} !== 3'b010) begin
        errors++; $display("FAIL exc_mid[%0d] got rv/busy/ack=%b expected 010", c, {redirect_valid, busy, exc_ack});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({redirect_valid, redirect_pc, csr_we, csr_addr, csr_wdata} !== {1'b1, 32'h8000, 1'b0, 12'h0, 32'h0}) begin
      errors++; $display("FAIL exc_redirect got rv=%b pc=%h we=%b addr=%h data=%h expected rv=1 pc=00008000 we=0 0 0",
                         redirect_valid, redirect_pc, csr_we, csr_addr, csr_wdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, redirect_valid, redirect_pc} !== {2'b00, 32'h8000}) begin
      errors++; $display("FAIL exc_after got busy=%b rv=%b pc=%h expected 0 0 00008000", busy, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_irq_vectored();
    logic [11:0] ea [4];
    logic [31:0] ed [4];
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ed = '{32'h300, 32'h8000_000B, 32'h0, 32'h1880};
    @(negedge clk);
    clear_inputs();
    irq = 1; mie_in = 32'h800; mstatus_in = 32'h8; mtvec_in = 32'h8001; exc_pc = 32'h303; exc_tval = 32'h1234;
    #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack, busy} !== 4'b0101) begin
      errors++; $display("FAIL irq_accept got acks/busy=%b expected 0101", {exc_ack, irq_ack, mret_ack, busy});
    end
    @(negedge clk);
    irq = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({csr_we, csr_addr, csr_wdata} !== {1'b1, ea[c], ed[c]}) begin
        errors++;
        $display("FAIL irq_csr[%0d] got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 c, csr_we, csr_addr, csr_wdata, ea[c], ed[c]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h802C}) begin
      errors++; $display("FAIL irq_redirect got rv=%b pc=%h expected rv=1 pc=0000802c", redirect_valid, redirect_pc);
    end
    @(negedge clk);
    irq = 1; mstatus_in = 32'h0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({irq_ack, busy} !== 2'b00) begin
        errors++; $display("FAIL irq_masked[%0d] got ack/busy=%b expected 00", c, {irq_ack, busy});
      end
      @(negedge clk);
    end
    irq = 0;
  endtask

  task automatic test_mret();
    @(negedge clk);
    clear_inputs();
    mret_valid = 1; mstatus_in = 32'h80; mepc_in = 32'h204;
    #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack, busy, flush} !== 5'b00111) begin
      errors++; $display("FAIL mret_accept got %b expected 00111", {exc_ack, irq_ack, mret_ack, busy, flush});
    end
    @(negedge clk);
    mret_valid = 0; mstatus_in = 0; mepc_in = 32'hFFFF_FFF0;
    #1;
    checks++;
    if ({csr_we, csr_addr, csr_wdata} !== {1'b1, 12'h300, 32'h1888}) begin
      errors++; $display("FAIL mret_status got we=%b addr=%h data=%h expected we=1 addr=300 data=00001888",
                         csr_we, csr_addr, csr_wdata);
    end
    @(negedge clk); #1;
    checks++;
    if ({redirect_valid, redirect_pc, csr_we} !== {1'b1, 32'h204, 1'b0}) begin
      errors++; $display("FAIL mret_redirect got rv=%b pc=%h we=%b expected rv=1 pc=00000204 we=0",
                         redirect_valid, redirect_pc, csr_we);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, redirect_valid} !== 2'b00) begin
      errors++; $display("FAIL mret_after got busy/rv=%b expected 00", {busy, redirect_valid});
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clear_inputs();
    exc_valid = 1; exc_cause = 5'd4; irq = 1; mret_valid = 1;
    mstatus_in = 32'h8; mie_in = 32'h800; mtvec_in = 32'h4000; mepc_in = 32'h600;
    #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack} !== 3'b100) begin
      errors++; $display("FAIL b2b_first got %b expected 100", {exc_ack, irq_ack, mret_ack});
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) exc_valid = 0;
      #1;
      checks++;
      if ({exc_ack, irq_ack, mret_ack} !== 3'b000) begin
        errors++; $display("FAIL b2b_busy_ack[%0d] got %b expected 000", c, {exc_ack, irq_ack, mret_ack});
      end
    end
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h4000}) begin
      errors++; $display("FAIL b2b_exc_redirect got rv=%b pc=%h expected rv=1 pc=00004000", redirect_valid, redirect_pc);
    end
    @(negedge clk); #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack, busy} !== 4'b0101) begin
      errors++; $display("FAIL b2b_second got %b expected 0101", {exc_ack, irq_ack, mret_ack, busy});
    end
    @(negedge clk);
    irq = 0; mret_valid = 0;
    #1;
    checks++;
    if ({csr_we, csr_addr, csr_wdata} !== {1'b1, 12'h341, 32'h0}) begin
      errors++; $display("FAIL b2b_irq_epc got we=%b addr=%h data=%h expected we=1 addr=341 data=0",
                         csr_we, csr_addr, csr_wdata);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({busy, redirect_valid, redirect_pc} !== {2'b00, 32'h4000}) begin
      errors++; $display("FAIL b2b_idle got busy=%b rv=%b pc=%h expected 0 0 00004000", busy, redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic [11:0] ea [4];
    logic [31:0] ed [4];
    ea = '{12'h341, 12'h342, 12'h343, 12'h300};
    ed = '{32'h404, 32'h7, 32'h55, 32'h1800};
    @(negedge clk);
    clear_inputs();
    exc_valid = 1; exc_cause = 5'd7; exc_pc = 32'h404; exc_tval = 32'h55; mtvec_in = 32'h1000;
    #1;
    checks++;
    if (exc_ack !== 1'b1) begin
      errors++; $display("FAIL rst_mid_accept got %b expected 1", exc_ack);
    end
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if ({csr_we, csr_addr} !== {1'b1, 12'h342}) begin
      errors++; $display("FAIL rst_mid_in_cause got we=%b addr=%h expected we=1 addr=342", csr_we, csr_addr);
    end
    reset = 0;
    #1;
    checks++;
    if ({exc_ack, irq_ack, mret_ack, csr_we, busy, flush, redirect_valid} !== 7'b0) begin
      errors++; $display("FAIL rst_mid_flags got %b expected 0000000",
                         {exc_ack, irq_ack, mret_ack, csr_we, busy, flush, redirect_valid});
    end
    checks++;
    if ({csr_addr, csr_wdata, redirect_pc} !== 76'h0) begin
      errors++; $display("FAIL rst_mid_data got addr=%h data=%h rpc=%h expected 0", csr_addr, csr_wdata, redirect_pc);
    end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if ({exc_ack, busy} !== 2'b11) begin
      errors++; $display("FAIL rst_mid_reaccept got ack/busy=%b expected 11", {exc_ack, busy});
    end
    @(negedge clk);
    exc_valid = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({csr_we, csr_addr, csr_wdata} !== {1'b1, ea[c], ed[c]}) begin
        errors++;
        $display("FAIL rst_mid_csr[%0d] got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 c, csr_we, csr_addr, csr_wdata, ea[c], ed[c]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1000}) begin
      errors++; $display("FAIL rst_mid_redirect got rv=%b pc=%h expected rv=1 pc=00001000", redirect_valid, redirect_pc);
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_irq_vectored();
    test_mret();
    test_back_to_back();
    test_reset_mid_sequence();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
